// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port synchronous
// memory. Requester 0 is the cpu (c_*), requester 1 is an auxiliary master
// (a_*). At most one memory op is issued per cycle. Read data is returned on
// the rvalid/rdata port of the requester that issued it, two cycles after
// the accept.
//
// Arbitration:
//   default                 fixed priority to the cpu. A starvation counter
//                           forces the aux requester to win once it has lost
//                           MAX_WAIT consecutive cycles.
//   MEM_ARBITER_RR_EN       round-robin. A 1-bit pointer selects the preferred
//                           requester on contention. After every grant the
//                           pointer moves to the other requester.
//
// Ports:
//   clk, rst_n                clock; asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata cpu command, held stable until c_gnt
//   c_gnt                     cpu command accepted this cycle (combinational)
//   c_rvalid/c_rdata          cpu read return; rdata holds between returns
//   a_*                       aux equivalents of the c_* ports
//   mem_re/mem_we             registered memory strobes
//   memaddr/wmemdata          registered memory address / write data
//   rmemdata                  memory read data, valid the cycle after mem_re
module mem_arbiter #(
  parameter int AWIDTH   = 16,
  parameter int DWIDTH   = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [AWIDTH-2:0] c_addr,
  input  logic [DWIDTH-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DWIDTH-1:0] c_rdata,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [AWIDTH-2:0] a_addr,
  input  logic [DWIDTH-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DWIDTH-1:0] a_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [AWIDTH-2:0] memaddr,
  output logic [DWIDTH-1:0] wmemdata,
  input  logic [DWIDTH-1:0] rmemdata
);

  logic              win_a;      // aux wins arbitration this cycle
  logic              tag_p1;     // requester id of the op now on mem_*
  logic [DWIDTH-1:0] c_rdata_q;
  logic [DWIDTH-1:0] a_rdata_q;

`ifdef MEM_ARBITER_RR_EN
  logic rr_ptr;                  // 0 = cpu preferred, 1 = aux preferred

  always_comb begin
    win_a = a_req;
    if (c_req && a_req) win_a = rr_ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (c_gnt || a_gnt) begin
      rr_ptr <= ~win_a;
    end
  end
`else
  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= MAX_W) ? MAX_W : v + 8'd1;
  endfunction

  always_comb begin
    win_a = a_req && (!c_req || (wait_cnt == MAX_W));
  end

  // Counts consecutive cycles the aux request has been held and refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (a_req && !a_gnt) begin
      wait_cnt <= sat_inc(wait_cnt);
    end else begin
      wait_cnt <= '0;
    end
  end
`endif

  // Grants are forced low while reset is asserted.
  assign a_gnt = rst_n & win_a;
  assign c_gnt = rst_n & c_req & ~win_a;

  // Stage p1: winning command registered onto the memory interface.
  // memaddr/wmemdata hold on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_re   <= 1'b0;
      mem_we   <= 1'b0;
      memaddr  <= '0;
      wmemdata <= '0;
      tag_p1   <= 1'b0;
    end else begin
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      if (c_gnt) begin
        mem_re   <= ~c_we;
        mem_we   <= c_we;
        memaddr  <= c_addr;
        wmemdata <= c_wdata;
        tag_p1   <= 1'b0;
      end else if (a_gnt) begin
        mem_re   <= ~a_we;
        mem_we   <= a_we;
        memaddr  <= a_addr;
        wmemdata <= a_wdata;
        tag_p1   <= 1'b1;
      end
    end
  end

  // Stage p2: mem_re is the read-valid of stage p1. It is routed by tag_p1
  // to the rvalid of the requester that issued the read. The memory drives
  // rmemdata during the rvalid cycle. That value is passed straight through,
  // then captured so that rdata holds until the next return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rvalid  <= 1'b0;
      a_rvalid  <= 1'b0;
      c_rdata_q <= '0;
      a_rdata_q <= '0;
    end else begin
      c_rvalid <= mem_re & ~tag_p1;
      a_rvalid <= mem_re & tag_p1;
      if (c_rvalid) c_rdata_q <= rmemdata;
      if (a_rvalid) a_rdata_q <= rmemdata;
    end
  end

  assign c_rdata = c_rvalid ? rmemdata : c_rdata_q;
  assign a_rdata = a_rvalid ? rmemdata : a_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. It contains a synchronous memory
// model and a reference shadow memory. Expected read returns (data and
// cycle) are queued per requester when a read is accepted. They are checked
// when the matching rvalid appears.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          c_req = 1'b0, c_we = 1'b0;
  logic [AW-2:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic          c_gnt, c_rvalid;
  logic [DW-1:0] c_rdata;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-2:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          a_gnt, a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          mem_re, mem_we;
  logic [AW-2:0] memaddr;
  logic [DW-1:0] wmemdata;
  logic [DW-1:0] rmemdata = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [31:0] c;
  } exp_t;

  exp_t c_q[$];
  exp_t a_q[$];

  logic [DW-1:0] mem    [0:32767];
  logic [DW-1:0] shadow [0:32767];

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .memaddr(memaddr),
    .wmemdata(wmemdata), .rmemdata(rmemdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: command sampled on posedge, read data next cycle.
  always @(posedge clk) begin
    if (mem_we) mem[memaddr] <= wmemdata;
    if (mem_re) rmemdata <= mem[memaddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Return monitor: every rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (c_rvalid) begin
      if (c_q.size() == 0) chk("c_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        e = c_q.pop_front();
        chk("c_rdata", 32'(c_rdata), 32'(e.d));
        chk("c_rvalid_cycle", 32'(cyc), e.c);
      end
    end
    if (a_rvalid) begin
      if (a_q.size() == 0) chk("a_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        e = a_q.pop_front();
        chk("a_rdata", 32'(a_rdata), 32'(e.d));
        chk("a_rvalid_cycle", 32'(cyc), e.c);
      end
    end
  end

  task automatic record(input bit who, input bit we, input logic [14:0] addr,
                        input logic [15:0] data);
    exp_t e;
    if (we) begin
      shadow[addr] = data;
    end else begin
      e.d = shadow[addr];
      e.c = 32'(cyc + 2);
      if (who) a_q.push_back(e);
      else c_q.push_back(e);
    end
  endtask

  // Issue one command from a negedge. Returns at the negedge after the grant
  // with the request dropped, so that chained calls keep req continuous.
  task automatic do_op(input bit who, input bit we, input logic [14:0] addr,
                       input logic [15:0] data);
    int n;
    logic g;
    if (!who) begin
      c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = data;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
    end
    #1;
    n = 0;
    g = who ? a_gnt : c_gnt;
    while (g !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
      g = who ? a_gnt : c_gnt;
    end
    if (who) chk("a_gnt_seen", 32'(g), 32'd1);
    else chk("c_gnt_seen", 32'(g), 32'd1);
    if (g === 1'b1) record(who, we, addr, data);
    @(negedge clk);
    if (!who) c_req = 1'b0;
    else a_req = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_memaddr", 32'(memaddr), 32'd0);
    chk("rst_wmemdata", 32'(wmemdata), 32'd0);
    chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_c_rdata", 32'(c_rdata), 32'd0);
    chk("rst_a_rdata", 32'(a_rdata), 32'd0);
    chk("rst_c_gnt", 32'(c_gnt), 32'd0);
    chk("rst_a_gnt", 32'(a_gnt), 32'd0);
  endtask

  initial begin
    bit exp_a;
    mem[15'h0001] = 16'h1111; shadow[15'h0001] = 16'h1111;
    mem[15'h0002] = 16'h2222; shadow[15'h0002] = 16'h2222;
    mem[15'h0003] = 16'h3333; shadow[15'h0003] = 16'h3333;

    // Reset state, with both requests high to show that grants are blocked.
    repeat (2) @(negedge clk);
    c_req = 1'b1; a_req = 1'b1;
    #1;
    chk_reset_outputs();
    c_req = 1'b0; a_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single cpu write, idle, then read back.
    do_op(1'b0, 1'b1, 15'h0010, 16'hBEEF);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_re", 32'(mem_re), 32'd0);
    chk("wr_memaddr", 32'(memaddr), 32'h0010);
    chk("wr_wmemdata", 32'(wmemdata), 32'hBEEF);
    @(negedge clk);
    chk("idle_mem_we", 32'(mem_we), 32'd0);
    chk("idle_mem_re", 32'(mem_re), 32'd0);
    chk("idle_memaddr_hold", 32'(memaddr), 32'h0010);
    chk("idle_wmemdata_hold", 32'(wmemdata), 32'hBEEF);
    do_op(1'b0, 1'b0, 15'h0010, 16'h0000);
    chk("rd_mem_re", 32'(mem_re), 32'd1);
    repeat (3) @(negedge clk);
    chk("rd_c_rdata_hold", 32'(c_rdata), 32'hBEEF);

    // Back-to-back cpu reads, one result per cycle, in order.
    do_op(1'b0, 1'b0, 15'h0001, 16'h0000);
    do_op(1'b0, 1'b0, 15'h0002, 16'h0000);
    do_op(1'b0, 1'b0, 15'h0003, 16'h0000);
    repeat (4) @(negedge clk);

    // Write/read hazard: aux write immediately followed by a cpu read.
    do_op(1'b1, 1'b1, 15'h0020, 16'h5A5A);
    do_op(1'b0, 1'b0, 15'h0020, 16'h0000);
    repeat (4) @(negedge clk);
    chk("hazard_c_rdata", 32'(c_rdata), 32'h5A5A);

    // A read by aux alone returns on the aux port.
    do_op(1'b1, 1'b0, 15'h0002, 16'h0000);
    repeat (4) @(negedge clk);

    // Reset while a read is in flight: nothing may come back.
    do_op(1'b0, 1'b0, 15'h0003, 16'h0000);
    chk("midrd_mem_re", 32'(mem_re), 32'd1);
    c_req = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    c_q.delete();
    a_q.delete();
    repeat (2) @(negedge clk);
    c_req = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_op(1'b0, 1'b0, 15'h0001, 16'h0000);
    repeat (4) @(negedge clk);

    // Continuous contention from a fresh reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 15'h0001;
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0002;
    for (int i = 0; i < 18; i++) begin
      #1;
`ifdef MEM_ARBITER_RR_EN
      exp_a = (i % 2) == 1;
`else
      exp_a = (i % 9) == 8;
`endif
      chk("cont_c_gnt", 32'(c_gnt), 32'(!exp_a));
      chk("cont_a_gnt", 32'(a_gnt), 32'(exp_a));
      record(exp_a, 1'b0, exp_a ? 15'h0002 : 15'h0001, 16'h0000);
      @(negedge clk);
    end
    c_req = 1'b0; a_req = 1'b0;
    repeat (5) @(negedge clk);

    chk("c_q_drained", 32'(c_q.size()), 32'd0);
    chk("a_q_drained", 32'(a_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter for the single-port synchronous memory; sits between cpu (requester 0), an auxiliary master (requester 1, e.g. DMA/debug loader) and the memory.
- Memory model: re/we/addr/wdata sampled on posedge clk; rdata valid the following cycle.
- Issues at most one memory op per cycle, returns read data tagged to the originating requester, and bounds aux starvation.

Parameters:
- AWIDTH, 16, address parameter; address buses are AWIDTH-1 bits wide ([AWIDTH-2:0]).
- DWIDTH, 16, data width.
- MAX_WAIT, 8, cycles a pending aux request may lose before it is forced to win (fixed-priority mode). Legal range 1..255.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- c_req  in  1  cpu request; held with c_we/c_addr/c_wdata stable until c_gnt.
- c_we  in  1  cpu op: 1 = write, 0 = read.
- c_addr  in  AWIDTH-1  cpu address.
- c_wdata  in  DWIDTH  cpu write data.
- c_gnt  out  1  cpu request accepted this cycle (combinational).
- c_rvalid  out  1  cpu read data valid.
- c_rdata  out  DWIDTH  cpu read data.
- a_req, a_we, a_addr, a_wdata, a_gnt, a_rvalid, a_rdata: aux equivalents, same widths/rules.
- mem_re  out  1  memory read strobe (registered).
- mem_we  out  1  memory write strobe (registered).
- memaddr  out  AWIDTH-1  memory address (registered).
- wmemdata  out  DWIDTH  memory write data (registered).
- rmemdata  in  DWIDTH  memory read data, valid one cycle after mem_re.

Behaviour:
- Reset (rst_n low, async): mem_re=0, mem_we=0, memaddr=0, wmemdata=0, c_rvalid=a_rvalid=0, c_rdata=a_rdata=0, wait counter=0, RR pointer=cpu, return-tag pipeline cleared. c_gnt/a_gnt=0 while in reset.
- Accept cycle N: exactly one of c_gnt/a_gnt is high if any req is high, else neither. The winner's command is registered onto mem_* at posedge ending N (visible in cycle N+1). Non-winners keep their req asserted; no gnt is issued for a dropped req.
- Idle cycle: mem_re=mem_we=0; memaddr/wmemdata hold their last value.
- Read return: for a read accepted in N, mem_re is high in N+1, and X_rvalid is high for exactly one cycle in N+2 with X_rdata = rmemdata (registered). Back-to-back reads therefore give 1 result per cycle. X_rdata holds until the next rvalid for that requester.
- Writes: no response; the write is complete at the end of N+1. A read of the same address accepted in N+1 returns the new data.
- Return tag: a 1-bit requester id plus a valid bit are pipelined alongside mem_re so that rvalid routes correctly under any interleaving.
- Fixed priority (default): cpu wins, except when wait_cnt == MAX_WAIT, where aux wins.
  - wait_cnt increments, saturating at MAX_WAIT, each cycle a_req is high and a_gnt is low.
  - wait_cnt clears to 0 on a_gnt or when a_req is low.
- Simultaneous req with no starvation: cpu granted. One requester only: it is granted the same cycle.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced after reset release. Requesters must re-issue.
- Address/data are passed through unmodified; no width conversion.

Optional Feature:
- MEM_ARBITER_RR_EN defined: fixed priority and wait_cnt are removed and replaced by round-robin.
  - 1-bit pointer names the preferred requester; it is used on contention.
  - After any grant, the pointer moves to the other requester.
  - Simultaneous continuous requests alternate c, a, c, a ...
- Undefined: fixed priority with MAX_WAIT starvation guard as above.

Test Plan:
- Reset: assert rst_n=0 mid-read (read accepted, mem_re high) -> all outputs 0 immediately; no c_rvalid after release.
- Single cpu write then read: c_req write addr 0x0010 data 0xBEEF, then read 0x0010 -> mem_we in N+1; c_rvalid in N'+2 with c_rdata=0xBEEF; a_rvalid never asserts.
- Back-to-back reads: cpu reads 0x0001, 0x0002, 0x0003 on consecutive accepts (memory preloaded 0x1111/0x2222/0x3333) -> c_rvalid high 3 consecutive cycles with data in order.
- Contention, fixed priority, MAX_WAIT=8: c_req and a_req held continuously -> cpu granted 8 cycles, aux granted on the 9th, pattern repeats; aux read data routed only to a_rdata.
- Contention with MEM_ARBITER_RR_EN: both reqs held continuously from reset -> grants alternate starting with cpu; interleaved reads return on the correct rvalid port 2 cycles after each grant.
- Write/read hazard: aux writes 0x0020=0x5A5A in N, cpu reads 0x0020 accepted N+1 -> c_rdata=0x5A5A.
